// File: rtl/e203_exu_regfile_mp.sv
// Multi-port integer register file with two writeback ports, optional write-to-read
// forwarding and a per-register pending bitmap for long-pipe results.
module e203_exu_regfile_mp #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RFIDX_W   = 5,
    parameter int unsigned RFREG_NUM = 32,
    parameter int unsigned RD_PORTS  = 3,
    parameter int unsigned BYPASS    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [RD_PORTS*RFIDX_W-1:0] rd_idx,
    output logic [RD_PORTS*XLEN-1:0]    rd_dat,
    output logic [RD_PORTS-1:0]         rd_pend,
    input  logic                        wbck0_wen,
    input  logic [RFIDX_W-1:0]          wbck0_idx,
    input  logic [XLEN-1:0]             wbck0_dat,
    input  logic                        wbck1_wen,
    input  logic [RFIDX_W-1:0]          wbck1_idx,
    input  logic [XLEN-1:0]             wbck1_dat,
    input  logic                        pend_set,
    input  logic [RFIDX_W-1:0]          pend_set_idx,
    output logic [RFREG_NUM-1:0]        pend_vec,
    output logic [XLEN-1:0]             x1_r
);

    logic [RFREG_NUM*XLEN-1:0] rf_flat;

    // x0 is hardwired; no storage exists for it
    assign rf_flat[XLEN-1:0] = '0;
    assign pend_vec[0]       = 1'b0;

    for (genvar i = 1; i < RFREG_NUM; i++) begin : g_reg
        logic [XLEN-1:0] reg_q;
        logic            pend_q;
        logic            hit0;
        logic            hit1;
        logic            hit_set;

        assign hit0    = wbck0_wen && (wbck0_idx == RFIDX_W'(i));
        assign hit1    = wbck1_wen && (wbck1_idx == RFIDX_W'(i));
        assign hit_set = pend_set && (pend_set_idx == RFIDX_W'(i));

        always_ff @(posedge clk) begin
            if (rst) begin
                reg_q  <= '0;
                pend_q <= 1'b0;
            end else begin
                if (hit0) begin
                    reg_q <= wbck0_dat;
                end else if (hit1) begin
                    reg_q <= wbck1_dat;
                end
                // a new long-pipe issue outranks the retiring result
                if (hit_set) begin
                    pend_q <= 1'b1;
                end else if (hit1) begin
                    pend_q <= 1'b0;
                end
            end
        end

        assign rf_flat[i*XLEN +: XLEN] = reg_q;
        assign pend_vec[i]             = pend_q;
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [RFIDX_W-1:0] idx;
        logic [XLEN-1:0]    dat;
        logic               pnd;
        logic               fwd_ok;

        assign idx = rd_idx[p*RFIDX_W +: RFIDX_W];

        always_comb begin
            dat    = '0;
            pnd    = 1'b0;
            fwd_ok = 1'b0;
            for (int unsigned r = 0; r < RFREG_NUM; r++) begin
                if (idx == RFIDX_W'(r)) begin
                    dat    = rf_flat[r*XLEN +: XLEN];
                    pnd    = pend_vec[r];
                    fwd_ok = (r != 0);
                end
            end
            // pending is never forwarded, only data
            if ((BYPASS != 0) && fwd_ok) begin
                if (wbck0_wen && (wbck0_idx == idx)) begin
                    dat = wbck0_dat;
                end else if (wbck1_wen && (wbck1_idx == idx)) begin
                    dat = wbck1_dat;
                end
            end
        end

        assign rd_dat[p*XLEN +: XLEN] = dat;
        assign rd_pend[p]             = pnd;
    end

    assign x1_r = rf_flat[XLEN +: XLEN];

endmodule

// File: tb/tb_e203_exu_regfile_mp.sv
// Bench for e203_exu_regfile_mp: three configurations (default, no forwarding, 16 regs)
// driven in lockstep and compared against an array-based reference model.
module tb_e203_exu_regfile_mp;

    localparam int XLEN = 32;
    localparam int IW   = 5;
    localparam int NP   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*IW-1:0]  rd_idx;
    logic              wbck0_wen, wbck1_wen, pend_set;
    logic [IW-1:0]     wbck0_idx, wbck1_idx, pend_set_idx;
    logic [XLEN-1:0]   wbck0_dat, wbck1_dat;

    logic [NP*XLEN-1:0] rd_dat_a, rd_dat_b, rd_dat_c;
    logic [NP-1:0]      rd_pend_a, rd_pend_b, rd_pend_c;
    logic [31:0]        pend_vec_a, pend_vec_b;
    logic [15:0]        pend_vec_c;
    logic [XLEN-1:0]    x1_a, x1_b, x1_c;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mem [3][32];
    bit          pnd [3][32];
    int          nregs [3] = '{32, 32, 16};
    bit          byp   [3] = '{1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    e203_exu_regfile_mp #(.BYPASS(1), .RFREG_NUM(32)) dut_a (
        .clk(clk), .rst(rst), .rd_idx(rd_idx), .rd_dat(rd_dat_a), .rd_pend(rd_pend_a),
        .wbck0_wen(wbck0_wen), .wbck0_idx(wbck0_idx), .wbck0_dat(wbck0_dat),
        .wbck1_wen(wbck1_wen), .wbck1_idx(wbck1_idx), .wbck1_dat(wbck1_dat),
        .pend_set(pend_set), .pend_set_idx(pend_set_idx), .pend_vec(pend_vec_a), .x1_r(x1_a)
    );

    e203_exu_regfile_mp #(.BYPASS(0), .RFREG_NUM(32)) dut_b (
        .clk(clk), .rst(rst), .rd_idx(rd_idx), .rd_dat(rd_dat_b), .rd_pend(rd_pend_b),
        .wbck0_wen(wbck0_wen), .wbck0_idx(wbck0_idx), .wbck0_dat(wbck0_dat),
        .wbck1_wen(wbck1_wen), .wbck1_idx(wbck1_idx), .wbck1_dat(wbck1_dat),
        .pend_set(pend_set), .pend_set_idx(pend_set_idx), .pend_vec(pend_vec_b), .x1_r(x1_b)
    );

    e203_exu_regfile_mp #(.BYPASS(1), .RFREG_NUM(16)) dut_c (
        .clk(clk), .rst(rst), .rd_idx(rd_idx), .rd_dat(rd_dat_c), .rd_pend(rd_pend_c),
        .wbck0_wen(wbck0_wen), .wbck0_idx(wbck0_idx), .wbck0_dat(wbck0_dat),
        .wbck1_wen(wbck1_wen), .wbck1_idx(wbck1_idx), .wbck1_dat(wbck1_dat),
        .pend_set(pend_set), .pend_set_idx(pend_set_idx), .pend_vec(pend_vec_c), .x1_r(x1_c)
    );

    function automatic bit legal(int k, int idx);
        return (idx != 0) && (idx < nregs[k]);
    endfunction

    function automatic logic [31:0] exp_rd(int k, int idx);
        if (!legal(k, idx)) return 32'h0;
        if (byp[k]) begin
            if (wbck0_wen && int'(wbck0_idx) == idx) return wbck0_dat;
            if (wbck1_wen && int'(wbck1_idx) == idx) return wbck1_dat;
        end
        return mem[k][idx];
    endfunction

    // Architectural effect of one clock edge
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                for (int r = 0; r < 32; r++) begin
                    mem[k][r] = 32'h0;
                    pnd[k][r] = 1'b0;
                end
            end else begin
                // port 1 applied first so port 0 overwrites it on a collision
                if (wbck1_wen && legal(k, int'(wbck1_idx))) mem[k][wbck1_idx] = wbck1_dat;
                if (wbck0_wen && legal(k, int'(wbck0_idx))) mem[k][wbck0_idx] = wbck0_dat;
                if (wbck1_wen && legal(k, int'(wbck1_idx))) pnd[k][wbck1_idx] = 1'b0;
                if (pend_set && legal(k, int'(pend_set_idx))) pnd[k][pend_set_idx] = 1'b1;
            end
        end
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        logic [NP*XLEN-1:0] dat;
        logic [NP-1:0]      pd;
        logic [31:0]        pv, epv;
        logic [XLEN-1:0]    x1;
        int                 idx;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin dat = rd_dat_a; pd = rd_pend_a; pv = pend_vec_a; x1 = x1_a; end
                1: begin dat = rd_dat_b; pd = rd_pend_b; pv = pend_vec_b; x1 = x1_b; end
                default: begin
                    dat = rd_dat_c; pd = rd_pend_c; pv = {16'h0, pend_vec_c}; x1 = x1_c;
                end
            endcase
            for (int p = 0; p < NP; p++) begin
                idx = int'(rd_idx[p*IW +: IW]);
                chk($sformatf("%s.i%0d.rd_dat%0d(x%0d)", tag, k, p, idx),
                    64'(dat[p*XLEN +: XLEN]), 64'(exp_rd(k, idx)));
                chk($sformatf("%s.i%0d.rd_pend%0d(x%0d)", tag, k, p, idx),
                    64'(pd[p]), 64'(legal(k, idx) ? pnd[k][idx] : 1'b0));
            end
            epv = '0;
            for (int r = 0; r < nregs[k]; r++) epv[r] = pnd[k][r];
            chk($sformatf("%s.i%0d.pend_vec", tag, k), 64'(pv), 64'(epv));
            chk($sformatf("%s.i%0d.x1_r", tag, k), 64'(x1), 64'(mem[k][1]));
        end
    endtask

    // Inputs are held for one cycle, checked mid-cycle, then committed at the edge
    task automatic cycle(string tag);
        #4;
        check_all(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0;
        wbck0_wen = 1'b0; wbck0_idx = '0; wbck0_dat = '0;
        wbck1_wen = 1'b0; wbck1_idx = '0; wbck1_dat = '0;
        pend_set  = 1'b0; pend_set_idx = '0;
    endtask

    task automatic set_rd(int a, int b, int c);
        rd_idx = {IW'(c), IW'(b), IW'(a)};
    endtask

    initial begin
        idle();
        set_rd(0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        model_edge();
        #1;

        idle();
        set_rd(1, 5, 31);
        cycle("reset");

        wbck0_wen = 1'b1; wbck0_idx = 5; wbck0_dat = 32'hDEADBEEF;
        cycle("wr_x5");
        idle();
        set_rd(5, 5, 5);
        cycle("rd_x5");

        wbck0_wen = 1'b1; wbck0_idx = 7; wbck0_dat = 32'h11;
        wbck1_wen = 1'b1; wbck1_idx = 7; wbck1_dat = 32'h22;
        set_rd(7, 7, 5);
        cycle("collide_x7");
        idle();
        cycle("after_x7");

        wbck0_wen = 1'b1; wbck0_idx = 3; wbck0_dat = 32'hA;
        cycle("wr_x3_a");
        wbck0_dat = 32'hB;
        set_rd(3, 7, 3);
        cycle("wr_x3_b_bypass");
        idle();
        cycle("rd_x3_b");

        pend_set = 1'b1; pend_set_idx = 9;
        set_rd(9, 9, 1);
        cycle("pset_x9");
        idle();
        cycle("pend_x9_a");
        cycle("pend_x9_b");
        wbck1_wen = 1'b1; wbck1_idx = 9; wbck1_dat = 32'h55;
        pend_set = 1'b1; pend_set_idx = 9;
        cycle("set_beats_clear");
        idle();
        cycle("x9_still_pending");
        wbck1_wen = 1'b1; wbck1_idx = 9; wbck1_dat = 32'h56;
        cycle("clr_x9");
        idle();
        cycle("x9_cleared");

        wbck0_wen = 1'b1; wbck0_idx = 0; wbck0_dat = 32'hFFFF_FFFF;
        pend_set = 1'b1; pend_set_idx = 0;
        wbck1_wen = 1'b1; wbck1_idx = 20; wbck1_dat = 32'h1;
        set_rd(0, 20, 16);
        cycle("wr_x0_x20");
        idle();
        cycle("rd_x0_x20");
        pend_set = 1'b1; pend_set_idx = 20;
        cycle("pset_x20");
        idle();
        set_rd(20, 0, 16);
        cycle("rd_x20_pend");

        for (int n = 0; n < 300; n++) begin
            rst          = ($urandom_range(0, 63) == 0);
            wbck0_wen    = 1'($urandom_range(0, 1));
            wbck0_idx    = IW'($urandom_range(0, 23));
            wbck0_dat    = $urandom;
            wbck1_wen    = 1'($urandom_range(0, 1));
            wbck1_idx    = IW'($urandom_range(0, 23));
            wbck1_dat    = $urandom;
            pend_set     = 1'($urandom_range(0, 1));
            pend_set_idx = IW'($urandom_range(0, 23));
            set_rd($urandom_range(0, 23), $urandom_range(0, 23), $urandom_range(0, 31));
            cycle("random");
        end

        idle();
        for (int i = 1; i < 32; i++) begin
            wbck0_wen = 1'b1; wbck0_idx = IW'(i); wbck0_dat = 32'h01010101 * i;
            pend_set = 1'b1; pend_set_idx = IW'(i);
            set_rd(i, 1, 15);
            cycle("fill");
        end
        idle();
        set_rd(1, 14, 31);
        cycle("filled");
        rst = 1'b1;
        wbck0_wen = 1'b1; wbck0_idx = 1; wbck0_dat = 32'h1;
        pend_set = 1'b1; pend_set_idx = 5;
        cycle("rst_with_wr");
        idle();
        cycle("post_rst");
        set_rd(5, 9, 31);
        cycle("post_rst_b");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
